// File: rtl/ltpi_phy_rx_framer_if.sv
// Decoded-symbol input bus and delivered-frame output bus of the LTPI receive framer.
// master: symbol source / frame consumer side; slave: the framer itself.
interface ltpi_phy_rx_framer_if;
    logic         rx_dv;
    logic [7:0]   rx_byte;
    logic         rx_is_k;
    logic         rx_code_err;
    logic         frm_valid;
    logic         frm_crc_err;
    logic [7:0]   frm_comma;
    logic [7:0]   frm_subtype;
    logic [103:0] frm_data;

    modport master (
        output rx_dv, rx_byte, rx_is_k, rx_code_err,
        input  frm_valid, frm_crc_err, frm_comma, frm_subtype, frm_data
    );

    modport slave (
        input  rx_dv, rx_byte, rx_is_k, rx_code_err,
        output frm_valid, frm_crc_err, frm_comma, frm_subtype, frm_data
    );
endinterface

// File: rtl/ltpi_phy_rx_framer.sv
// LTPI PHY receive framer: aligns 16-byte comma-delimited frames, checks CRC-8 (poly 0x07),
// tracks HUNT/ALIGN/LOCKED alignment and delivers good frames while locked.
module ltpi_phy_rx_framer #(
    parameter int unsigned CRC_REFLECTOR = 0,
    parameter int unsigned LOCK_FRAMES   = 3,
    parameter int unsigned UNLOCK_ERRS   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    ltpi_phy_rx_framer_if.slave       rx_if,
    input  logic                      cnt_clr,
    output logic                      aligned,
    output logic [3:0]                rx_frm_offset,
    output logic [15:0]               crc_err_cnt
);
    typedef enum logic [1:0] {ST_HUNT, ST_ALIGN, ST_LOCKED} state_t;

    function automatic logic [7:0] bit_rev(input logic [7:0] v);
        logic [7:0] r;
        for (int unsigned i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     offset_q, offset_d;
    logic [2:0]     good_cnt_q, good_cnt_d;
    logic [2:0]     bad_cnt_q, bad_cnt_d;
    logic [7:0]     crc_q, crc_d;
    logic           frame_bad_q, frame_bad_d;
    logic [7:0]     comma_buf_q, comma_buf_d;
    logic [7:0]     sub_buf_q, sub_buf_d;
    logic [103:0]   data_buf_q, data_buf_d;
    logic           frm_valid_q, frm_valid_d;
    logic           frm_crc_err_q, frm_crc_err_d;
    logic [7:0]     frm_comma_q, frm_comma_d;
    logic [7:0]     frm_subtype_q, frm_subtype_d;
    logic [103:0]   frm_data_q, frm_data_d;
    logic           aligned_q, aligned_d;
    logic [15:0]    crc_err_cnt_q, crc_err_cnt_d;

    logic           is_comma;
    logic [7:0]     crc_in;
    logic [7:0]     crc_fin;
    logic           frame_end;
    logic           frame_good;
    logic           frame_abort;
    logic           frame_lost;
    logic           drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            offset_q      <= '0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            crc_q         <= '0;
            frame_bad_q   <= 1'b0;
            comma_buf_q   <= '0;
            sub_buf_q     <= '0;
            data_buf_q    <= '0;
            frm_valid_q   <= 1'b0;
            frm_crc_err_q <= 1'b0;
            frm_comma_q   <= '0;
            frm_subtype_q <= '0;
            frm_data_q    <= '0;
            aligned_q     <= 1'b0;
            crc_err_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            crc_q         <= crc_d;
            frame_bad_q   <= frame_bad_d;
            comma_buf_q   <= comma_buf_d;
            sub_buf_q     <= sub_buf_d;
            data_buf_q    <= data_buf_d;
            frm_valid_q   <= frm_valid_d;
            frm_crc_err_q <= frm_crc_err_d;
            frm_comma_q   <= frm_comma_d;
            frm_subtype_q <= frm_subtype_d;
            frm_data_q    <= frm_data_d;
            aligned_q     <= aligned_d;
            crc_err_cnt_q <= crc_err_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        good_cnt_d    = good_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        crc_d         = crc_q;
        frame_bad_d   = frame_bad_q;
        comma_buf_d   = comma_buf_q;
        sub_buf_d     = sub_buf_q;
        data_buf_d    = data_buf_q;
        frm_valid_d   = 1'b0;
        frm_crc_err_d = 1'b0;
        frm_comma_d   = frm_comma_q;
        frm_subtype_d = frm_subtype_q;
        frm_data_d    = frm_data_q;
        crc_err_cnt_d = crc_err_cnt_q;
        frame_end     = 1'b0;
        frame_good    = 1'b0;
        frame_abort   = 1'b0;
        frame_lost    = 1'b0;
        drop          = 1'b0;

        is_comma = rx_if.rx_is_k && (rx_if.rx_byte == 8'hBC || rx_if.rx_byte == 8'hDC);
        crc_in   = (CRC_REFLECTOR != 0) ? bit_rev(rx_if.rx_byte) : rx_if.rx_byte;
        crc_fin  = (CRC_REFLECTOR != 0) ? bit_rev(crc_q) : crc_q;

        if (rx_if.rx_dv) begin
            if (is_comma) begin
                // Every comma starts a new frame; one arriving mid-frame also aborts the old one
                offset_d    = 4'd1;
                crc_d       = '0;
                frame_bad_d = rx_if.rx_code_err;
                comma_buf_d = rx_if.rx_byte;
                if (state_q == ST_HUNT) begin
                    state_d    = ST_ALIGN;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end else if (offset_q != 4'd0) begin
                    frame_abort = 1'b1;
                end
            end else if (state_q != ST_HUNT) begin
                if (offset_q == 4'd0) begin
                    frame_lost = 1'b1;
                end else begin
                    offset_d    = offset_q + 4'd1;
                    frame_bad_d = frame_bad_q | rx_if.rx_code_err | rx_if.rx_is_k;
                    if (offset_q == 4'd1) sub_buf_d = rx_if.rx_byte;
                    for (int unsigned i = 0; i < 13; i++) begin
                        if (offset_q == 4'(i + 2)) data_buf_d[8*i +: 8] = rx_if.rx_byte;
                    end
                    if (offset_q == 4'd15) begin
                        frame_end  = 1'b1;
                        frame_good = !frame_bad_d && (crc_fin == rx_if.rx_byte);
                    end else begin
                        crc_d = crc8_next(crc_q, crc_in);
                    end
                end
            end
        end

        if (frame_end && frame_good) begin
            if (state_q == ST_LOCKED || (good_cnt_q + 3'd1) == 3'(LOCK_FRAMES)) begin
                state_d       = ST_LOCKED;
                bad_cnt_d     = '0;
                frm_valid_d   = 1'b1;
                frm_comma_d   = comma_buf_q;
                frm_subtype_d = sub_buf_q;
                frm_data_d    = data_buf_d;
            end else begin
                good_cnt_d = good_cnt_q + 3'd1;
            end
        end else if (frame_end || frame_abort || frame_lost) begin
            if (state_q == ST_LOCKED) begin
                frm_crc_err_d = 1'b1;
                if (frame_lost || (bad_cnt_q + 3'd1) == 3'(UNLOCK_ERRS)) drop = 1'b1;
                else bad_cnt_d = bad_cnt_q + 3'd1;
            end else begin
                drop = 1'b1;
            end
        end

        if (drop) begin
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            // An aborting comma has already opened the next frame, so HUNT is passed straight through
            if (frame_abort) begin
                state_d = ST_ALIGN;
            end else begin
                state_d  = ST_HUNT;
                offset_d = '0;
            end
        end

        if (cnt_clr) crc_err_cnt_d = '0;
        else if (frm_crc_err_d && crc_err_cnt_q != 16'hFFFF) crc_err_cnt_d = crc_err_cnt_q + 16'd1;

        aligned_d = (state_d == ST_LOCKED);
    end

    assign rx_if.frm_valid   = frm_valid_q;
    assign rx_if.frm_crc_err = frm_crc_err_q;
    assign rx_if.frm_comma   = frm_comma_q;
    assign rx_if.frm_subtype = frm_subtype_q;
    assign rx_if.frm_data    = frm_data_q;
    assign aligned           = aligned_q;
    assign rx_frm_offset     = offset_q;
    assign crc_err_cnt       = crc_err_cnt_q;
endmodule

// File: tb/tb_ltpi_phy_rx_framer.sv
// Directed bench for ltpi_phy_rx_framer: lock, CRC errors, comma abort, gaps, saturation,
// unlock, code errors, offset-0 loss and async reset mid-frame.
module tb_ltpi_phy_rx_framer;
    logic        clk = 1'b0;
    logic        reset;
    logic        cnt_clr;
    logic        aligned;
    logic [3:0]  rx_frm_offset;
    logic [15:0] crc_err_cnt;

    ltpi_phy_rx_framer_if bus();

    ltpi_phy_rx_framer #(.CRC_REFLECTOR(0), .LOCK_FRAMES(3), .UNLOCK_ERRS(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_if         (bus),
        .cnt_clr       (cnt_clr),
        .aligned       (aligned),
        .rx_frm_offset (rx_frm_offset),
        .crc_err_cnt   (crc_err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [15:0] exp_cnt;
    logic [7:0]  frm [16];
    logic [15:0] kmask;
    logic [15:0] emask;

    always @(posedge clk) begin
        #1;
        if (bus.frm_valid === 1'b1) n_valid++;
        if (bus.frm_crc_err === 1'b1) n_err++;
    end

    function automatic logic [7:0] ref_crc();
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int b = 1; b < 15; b++) begin
            for (int j = 7; j >= 0; j--) begin
                fb = c[7] ^ frm[b][j];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic build_good(input logic [7:0] sub, input logic [7:0] base);
        frm[0] = 8'hBC;
        frm[1] = sub;
        for (int i = 0; i < 13; i++) frm[2+i] = base + 8'(i);
        frm[15] = ref_crc();
        kmask = 16'h0001;
        emask = 16'h0000;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.rx_dv = 1'b0; bus.rx_byte = 8'h00; bus.rx_is_k = 1'b0; bus.rx_code_err = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic k, input logic e, input int gap);
        repeat (gap) idle();
        @(negedge clk);
        bus.rx_dv = 1'b1; bus.rx_byte = b; bus.rx_is_k = k; bus.rx_code_err = e;
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < 16; i++) send_byte(frm[i], kmask[i], emask[i], gap);
        idle();
    endtask

    task automatic do_lock();
        for (int f = 0; f < 3; f++) begin
            build_good(8'h01, 8'h00);
            send_frame(0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cnt_clr = 1'b0;
        bus.rx_dv = 1'b0; bus.rx_byte = 8'h00; bus.rx_is_k = 1'b0; bus.rx_code_err = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (aligned !== 1'b0) begin bad++; $display("FAIL reset_aligned got=%b want=0", aligned); end
        total++; if (rx_frm_offset !== 4'd0) begin bad++; $display("FAIL reset_offset got=%0d want=0", rx_frm_offset); end
        total++; if (crc_err_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0000", crc_err_cnt); end
        total++; if ({bus.frm_valid, bus.frm_crc_err} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {bus.frm_valid, bus.frm_crc_err}); end
        total++; if (bus.frm_data !== 104'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.frm_data); end
        reset = 1'b0;
        exp_cnt = 16'h0;
    endtask

    task automatic test_lock();
        int v0;
        v0 = n_valid;
        build_good(8'h01, 8'h00);
        send_frame(0);
        send_frame(0);
        total++; if (aligned !== 1'b0) begin bad++; $display("FAIL lock_early got=%b want=0", aligned); end
        send_frame(0);
        total++; if (aligned !== 1'b1) begin bad++; $display("FAIL lock_aligned got=%b want=1", aligned); end
        total++; if (bus.frm_valid !== 1'b1) begin bad++; $display("FAIL lock_valid got=%b want=1", bus.frm_valid); end
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL lock_valid_count got=%0d want=1", n_valid - v0); end
        total++; if (bus.frm_data[7:0] !== 8'h00) begin bad++; $display("FAIL lock_data0 got=%h want=00", bus.frm_data[7:0]); end
        total++; if (bus.frm_data[103:96] !== 8'h0C) begin bad++; $display("FAIL lock_data12 got=%h want=0c", bus.frm_data[103:96]); end
        total++; if ({bus.frm_comma, bus.frm_subtype} !== 16'hBC01) begin bad++; $display("FAIL lock_hdr got=%h want=bc01", {bus.frm_comma, bus.frm_subtype}); end
        total++; if (rx_frm_offset !== 4'd0) begin bad++; $display("FAIL lock_offset got=%0d want=0", rx_frm_offset); end
        idle();
        total++; if (bus.frm_valid !== 1'b0) begin bad++; $display("FAIL lock_pulse_width got=%b want=0", bus.frm_valid); end
    endtask

    task automatic test_crc_err();
        int v0;
        build_good(8'h01, 8'h00);
        frm[15] = frm[15] ^ 8'h01;
        v0 = n_valid;
        send_frame(0);
        exp_cnt = exp_cnt + 16'd1;
        total++; if (bus.frm_crc_err !== 1'b1) begin bad++; $display("FAIL crc_err_pulse got=%b want=1", bus.frm_crc_err); end
        total++; if (crc_err_cnt !== exp_cnt) begin bad++; $display("FAIL crc_err_cnt got=%h want=%h", crc_err_cnt, exp_cnt); end
        total++; if (aligned !== 1'b1) begin bad++; $display("FAIL crc_err_aligned got=%b want=1", aligned); end
        total++; if (n_valid != v0) begin bad++; $display("FAIL crc_err_novalid got=%0d want=%0d", n_valid, v0); end
        build_good(8'h02, 8'h10);
        send_frame(0);
        total++; if (bus.frm_valid !== 1'b1) begin bad++; $display("FAIL crc_recover_valid got=%b want=1", bus.frm_valid); end
        total++; if ({bus.frm_subtype, bus.frm_data[7:0]} !== 16'h0210) begin bad++; $display("FAIL crc_recover_data got=%h want=0210", {bus.frm_subtype, bus.frm_data[7:0]}); end
    endtask

    task automatic test_comma_abort();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        build_good(8'h01, 8'h20);
        for (int i = 0; i < 7; i++) send_byte(frm[i], kmask[i], emask[i], 0);
        build_good(8'h03, 8'h30);
        send_frame(0);
        exp_cnt = exp_cnt + 16'd1;
        total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL abort_err_count got=%0d want=1", n_err - e0); end
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL abort_valid_count got=%0d want=1", n_valid - v0); end
        total++; if ({bus.frm_subtype, bus.frm_data[7:0]} !== 16'h0330) begin bad++; $display("FAIL abort_data got=%h want=0330", {bus.frm_subtype, bus.frm_data[7:0]}); end
        total++; if (crc_err_cnt !== exp_cnt) begin bad++; $display("FAIL abort_cnt got=%h want=%h", crc_err_cnt, exp_cnt); end
    endtask

    task automatic test_gaps();
        int v0;
        v0 = n_valid;
        build_good(8'h04, 8'h40);
        send_frame(2);
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL gaps_valid got=%0d want=1", n_valid - v0); end
        total++; if (bus.frm_data[103:96] !== 8'h4C) begin bad++; $display("FAIL gaps_data12 got=%h want=4c", bus.frm_data[103:96]); end
    endtask

    task automatic test_k_in_data();
        int v0;
        v0 = n_valid;
        build_good(8'h05, 8'h50);
        frm[6] = 8'h1C;
        kmask[6] = 1'b1;
        frm[15] = ref_crc();
        send_frame(0);
        exp_cnt = exp_cnt + 16'd1;
        total++; if (bus.frm_crc_err !== 1'b1) begin bad++; $display("FAIL kdata_err got=%b want=1", bus.frm_crc_err); end
        total++; if (n_valid != v0) begin bad++; $display("FAIL kdata_novalid got=%0d want=%0d", n_valid, v0); end
        build_good(8'h01, 8'h00);
        send_frame(0);
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut.crc_err_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.crc_err_cnt_q;
        build_good(8'h01, 8'h00);
        frm[15] = frm[15] ^ 8'h80;
        send_frame(0);
        total++; if (crc_err_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", crc_err_cnt); end
        for (int i = 0; i < 15; i++) send_byte(frm[i], kmask[i], emask[i], 0);
        send_byte(frm[15], 1'b0, 1'b0, 0);
        cnt_clr = 1'b1;
        idle();
        cnt_clr = 1'b0;
        total++; if (bus.frm_crc_err !== 1'b1) begin bad++; $display("FAIL clr_pulse got=%b want=1", bus.frm_crc_err); end
        total++; if (crc_err_cnt !== 16'h0) begin bad++; $display("FAIL clr_wins got=%h want=0000", crc_err_cnt); end
        exp_cnt = 16'h0;
        build_good(8'h01, 8'h00);
        send_frame(0);
        total++; if (aligned !== 1'b1) begin bad++; $display("FAIL sat_aligned got=%b want=1", aligned); end
    endtask

    task automatic test_unlock();
        build_good(8'h01, 8'h00);
        frm[15] = frm[15] ^ 8'h02;
        for (int f = 0; f < 3; f++) begin
            send_frame(0);
            exp_cnt = exp_cnt + 16'd1;
            if (f < 2) begin
                total++; if (aligned !== 1'b1) begin bad++; $display("FAIL unlock_early%0d got=%b want=1", f, aligned); end
            end
        end
        total++; if (aligned !== 1'b0) begin bad++; $display("FAIL unlock_aligned got=%b want=0", aligned); end
        total++; if (rx_frm_offset !== 4'd0) begin bad++; $display("FAIL unlock_offset got=%0d want=0", rx_frm_offset); end
        total++; if (crc_err_cnt !== exp_cnt) begin bad++; $display("FAIL unlock_cnt got=%h want=%h", crc_err_cnt, exp_cnt); end
    endtask

    task automatic test_code_err();
        int v0;
        v0 = n_valid;
        build_good(8'h01, 8'h00);
        send_frame(0);
        emask[4] = 1'b1;
        send_frame(0);
        emask[4] = 1'b0;
        total++; if (aligned !== 1'b0) begin bad++; $display("FAIL coderr_aligned got=%b want=0", aligned); end
        send_frame(0);
        send_frame(0);
        total++; if (aligned !== 1'b0) begin bad++; $display("FAIL coderr_relock_early got=%b want=0", aligned); end
        send_frame(0);
        total++; if (aligned !== 1'b1) begin bad++; $display("FAIL coderr_relock got=%b want=1", aligned); end
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL coderr_valid_count got=%0d want=1", n_valid - v0); end
    endtask

    task automatic test_offset0_noncomma();
        int e0;
        e0 = n_err;
        send_byte(8'h55, 1'b0, 1'b0, 0);
        idle();
        exp_cnt = exp_cnt + 16'd1;
        total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL off0_err got=%0d want=1", n_err - e0); end
        total++; if (aligned !== 1'b0) begin bad++; $display("FAIL off0_aligned got=%b want=0", aligned); end
        total++; if (crc_err_cnt !== exp_cnt) begin bad++; $display("FAIL off0_cnt got=%h want=%h", crc_err_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        do_lock();
        total++; if (aligned !== 1'b1) begin bad++; $display("FAIL rmid_prelock got=%b want=1", aligned); end
        build_good(8'h06, 8'h60);
        for (int i = 0; i < 6; i++) send_byte(frm[i], kmask[i], emask[i], 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++; if (aligned !== 1'b0) begin bad++; $display("FAIL rmid_async_aligned got=%b want=0", aligned); end
        total++; if (rx_frm_offset !== 4'd0) begin bad++; $display("FAIL rmid_async_offset got=%0d want=0", rx_frm_offset); end
        total++; if (crc_err_cnt !== 16'h0) begin bad++; $display("FAIL rmid_async_cnt got=%h want=0000", crc_err_cnt); end
        total++; if (bus.frm_data !== 104'h0) begin bad++; $display("FAIL rmid_async_data got=%h want=0", bus.frm_data); end
        idle();
        reset = 1'b0;
        for (int i = 6; i < 16; i++) send_byte(frm[i], kmask[i], emask[i], 0);
        idle();
        total++; if (rx_frm_offset !== 4'd0) begin bad++; $display("FAIL rmid_hunt_offset got=%0d want=0", rx_frm_offset); end
        build_good(8'h01, 8'h00);
        send_frame(0);
        send_frame(0);
        total++; if (aligned !== 1'b0) begin bad++; $display("FAIL rmid_early got=%b want=0", aligned); end
        send_frame(0);
        total++; if (aligned !== 1'b1) begin bad++; $display("FAIL rmid_relock got=%b want=1", aligned); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_crc_err();
        test_comma_abort();
        test_gaps();
        test_k_in_data();
        test_saturate();
        test_unlock();
        test_code_err();
        test_offset0_noncomma();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ltpi_phy_rx_framer.md
LTPI_PHY_RX_FRAMER -- requirements
Module: ltpi_phy_rx_framer

Interface
REQ-001 SHALL have parameter CRC_REFLECTOR, default 0; when 1, each byte is bit-reversed before the CRC engine and the CRC result is bit-reversed.
REQ-002 SHALL have parameter LOCK_FRAMES, default 3; consecutive good frames needed to declare alignment (legal 1..7).
REQ-003 SHALL have parameter UNLOCK_ERRS, default 3; consecutive bad frames that drop alignment (legal 1..7).
REQ-004 clk  input  1  system clock; all logic is on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx_dv  input  1  decoded byte valid strobe from the 8b10b decoder; asserted for 1 clk per symbol.
REQ-007 rx_byte  input  8  decoded byte.
REQ-008 rx_is_k  input  1  rx_byte is a K character.
REQ-009 rx_code_err  input  1  disparity or code violation on this symbol.
REQ-010 cnt_clr  input  1  synchronous clear of crc_err_cnt.
REQ-011 frm_valid  output  1  1-clk pulse: good frame delivered.
REQ-012 frm_crc_err  output  1  1-clk pulse: bad frame while LOCKED.
REQ-013 frm_comma  output  8  comma byte of the last delivered frame.
REQ-014 frm_subtype  output  8  frame subtype byte.
REQ-015 frm_data  output  104  data[0..12]; data[i] occupies bits [8i+7:8i].
REQ-016 aligned  output  1  high in LOCKED state.
REQ-017 rx_frm_offset  output  4  index of the next expected byte in the frame.
REQ-018 crc_err_cnt  output  16  saturating count of bad frames while LOCKED.

Function
REQ-019 A frame SHALL be 16 bytes at offsets 0..15: 0 comma, 1 subtype, 2..14 data[0..12], 15 CRC.
REQ-020 A comma SHALL be rx_is_k=1 with rx_byte 8'hBC (K28.5) or 8'hDC (K28.6).
REQ-021 CRC SHALL be CRC-8, polynomial 0x07, init 8'h00, MSB first, computed over offsets 1..14 and compared with byte 15.
REQ-022 A good frame SHALL satisfy all of: CRC match, no rx_code_err on any byte, and no K character at offsets 1..15.
REQ-023 State HUNT: rx_frm_offset SHALL be 0. A comma SHALL set offset to 1 and move to ALIGN with good count 0. A non-comma SHALL be discarded.
REQ-024 State ALIGN: when a frame ends at byte 15, a good frame SHALL increment the good count. Reaching LOCK_FRAMES SHALL move to LOCKED. A bad frame SHALL move to HUNT.
REQ-025 State LOCKED: a good frame SHALL clear the bad count. A bad frame SHALL increment it. Reaching UNLOCK_ERRS SHALL move to HUNT.
REQ-026 rx_frm_offset SHALL advance only on rx_dv and SHALL wrap 15->0.
REQ-027 In ALIGN or LOCKED, a non-comma at offset 0 SHALL mark the frame bad immediately and move to HUNT.
REQ-028 In ALIGN or LOCKED, a comma at offsets 1..15 SHALL abort the current frame and count it as bad. Offset SHALL become 1, and the comma SHALL start the new frame.
REQ-029 frm_valid SHALL pulse on the clk after the byte-15 rx_dv cycle, only for a good frame in LOCKED, including the frame that completes LOCK_FRAMES.
REQ-030 frm_comma, frm_subtype and frm_data SHALL update in the same cycle as frm_valid and hold their values otherwise.
REQ-031 frm_crc_err SHALL pulse with the same timing as frm_valid, for a bad frame or an aborted frame while LOCKED.
REQ-032 crc_err_cnt SHALL increment on each frm_crc_err and saturate at 16'hFFFF. cnt_clr SHALL win over a simultaneous increment.
REQ-033 Gaps in rx_dv of any length SHALL NOT affect state or CRC.
REQ-034 aligned SHALL be registered and SHALL change on the clk of the state transition.

Reset
REQ-035 On reset assertion, without waiting for clk: state SHALL be HUNT; offset, counters, CRC, frm_valid, frm_crc_err, aligned, frm_comma, frm_subtype, frm_data and crc_err_cnt SHALL all be 0.
REQ-036 Reset mid-frame SHALL discard the partial frame. After release, the block SHALL require a fresh comma followed by LOCK_FRAMES good frames before it asserts aligned.

Verification
REQ-037 Stream 3 good frames (comma BC, subtype 01, data 00..0C, correct CRC) -> aligned rises after the 3rd frame; 1 frm_valid pulse with frm_data[7:0]=00 and frm_data[103:96]=0C.
REQ-038 LOCKED, then 1 frame with a corrupted CRC byte -> frm_crc_err=1, crc_err_cnt=1, aligned stays 1; the next good frame produces frm_valid.
REQ-039 LOCKED, then 3 consecutive bad frames -> aligned falls the clk after the 3rd frame's byte 15; state HUNT; rx_frm_offset=0.
REQ-040 LOCKED, then comma BC injected at offset 7 -> frm_crc_err pulse; the next 15 bytes form a good frame and produce frm_valid.
REQ-041 rx_code_err on byte 4 in ALIGN -> return to HUNT, no frm_valid; 3 further good frames are needed to reach aligned=1.
REQ-042 Force crc_err_cnt to 16'hFFFF, then 1 bad frame -> count stays FFFF; cnt_clr asserted together with a bad frame -> count=0.
